// File: rtl/icosoc_pinevent_pkg.sv
// Shared constants for the pin-event block: bus widths and register map.
package icosoc_pinevent_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DIV_W  = 16;

    typedef enum logic [ADDR_W-1:0] {
        REG_LEVEL   = 8'h00,
        REG_RISE_EN = 8'h04,
        REG_FALL_EN = 8'h08,
        REG_STATUS  = 8'h0C,
        REG_DIV     = 8'h10
    } reg_addr_e;

endpackage

// File: rtl/icosoc_pinevent_filter.sv
// One pin: 2-flop synchronizer, 3-sample history taken on prescaler ticks,
// debounced level and one-cycle rise/fall pulses aligned with the level change.
module icosoc_pinevent_filter (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    input  logic tick_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic [2:0] hist_q, hist_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    // The decision looks at the history including the sample taken this tick,
    // so the level moves on the same edge that captures the third agreeing sample.
    always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        if (tick_i) begin
            hist_d = {hist_q[1:0], sync_q[1]};
            if (hist_d == 3'b111 && !level_q) begin
                level_d = 1'b1;
            end else if (hist_d == 3'b000 && level_q) begin
                level_d = 1'b0;
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            hist_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin_i};
            hist_q  <= hist_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/icosoc_mod_pinevent.sv
// Debounced pin-event monitor: prescaled sampling, edge enables, W1C status,
// level interrupt, and a simple held-request register bus.
module icosoc_mod_pinevent
    import icosoc_pinevent_pkg::*;
#(
    parameter int          IO_LENGTH   = 32,
    parameter logic [15:0] DEFAULT_DIV = 16'd999
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IO_LENGTH-1:0] pin_in,
    input  logic                 ctrl_wr,
    input  logic                 ctrl_rd,
    input  logic [ADDR_W-1:0]    ctrl_addr,
    input  logic [DATA_W-1:0]    ctrl_wdat,
    output logic [DATA_W-1:0]    ctrl_rdat,
    output logic                 ctrl_done,
    output logic                 irq
);

    logic [IO_LENGTH-1:0] level, rise, fall;
    logic [IO_LENGTH-1:0] rise_en_q, rise_en_d;
    logic [IO_LENGTH-1:0] fall_en_q, fall_en_d;
    logic [IO_LENGTH-1:0] status_q, status_d;
    logic [IO_LENGTH-1:0] clr_mask;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic                 tick;
    logic                 done_q, done_d;
    logic [DATA_W-1:0]    rdat_q, rdat_d;
    logic [DATA_W-1:0]    rd_mux;
    logic                 irq_q;
    logic                 req, wr_en;

    assign tick = (cnt_q == '0);

    generate
        for (genvar gi = 0; gi < IO_LENGTH; gi++) begin : g_pin
            icosoc_pinevent_filter u_filter (
                .clk     (clk),
                .reset   (reset),
                .pin_i   (pin_in[gi]),
                .tick_i  (tick),
                .level_o (level[gi]),
                .rise_o  (rise[gi]),
                .fall_o  (fall[gi])
            );
        end
    endgenerate

    always_comb begin
        // Blocking on done_q makes a held request complete once per pulse.
        req   = (ctrl_wr | ctrl_rd) & ~done_q;
        wr_en = req & ctrl_wr;

        rd_mux = '0;
        case (ctrl_addr)
            REG_LEVEL:   rd_mux = DATA_W'(level);
            REG_RISE_EN: rd_mux = DATA_W'(rise_en_q);
            REG_FALL_EN: rd_mux = DATA_W'(fall_en_q);
            REG_STATUS:  rd_mux = DATA_W'(status_q);
            REG_DIV:     rd_mux = DATA_W'(div_q);
            default:     rd_mux = '0;
        endcase

        done_d = req;
        rdat_d = (req && ctrl_rd && !ctrl_wr) ? rd_mux : '0;

        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_mask  = '0;
        div_d     = div_q;
        cnt_d     = tick ? div_q : DIV_W'(cnt_q - 16'd1);

        if (wr_en) begin
            case (ctrl_addr)
                REG_RISE_EN: rise_en_d = ctrl_wdat[IO_LENGTH-1:0];
                REG_FALL_EN: fall_en_d = ctrl_wdat[IO_LENGTH-1:0];
                REG_STATUS:  clr_mask  = ctrl_wdat[IO_LENGTH-1:0];
                REG_DIV: begin
                    div_d = ctrl_wdat[DIV_W-1:0];
                    cnt_d = ctrl_wdat[DIV_W-1:0];
                end
                default: ;
            endcase
        end

        // New events are OR-ed in after the clear so a coincident set wins.
        status_d = (status_q & ~clr_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            div_q     <= DEFAULT_DIV;
            cnt_q     <= DEFAULT_DIV;
            done_q    <= 1'b0;
            rdat_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            rdat_q    <= rdat_d;
            irq_q     <= |status_q;
        end
    end

    assign ctrl_rdat = rdat_q;
    assign ctrl_done = done_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_icosoc_mod_pinevent.sv
// Directed bench for icosoc_mod_pinevent: register table, handshake, filter
// latency, glitch rejection, W1C/set priority, reset abort and power-up events.
module tb_icosoc_mod_pinevent;

    localparam int IO_LEN = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [IO_LEN-1:0] pin_in;
    logic              ctrl_wr, ctrl_rd;
    logic [7:0]        ctrl_addr;
    logic [31:0]       ctrl_wdat;
    logic [31:0]       ctrl_rdat;
    logic              ctrl_done;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    icosoc_mod_pinevent #(
        .IO_LENGTH   (IO_LEN),
        .DEFAULT_DIV (16'd999)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pin_in    (pin_in),
        .ctrl_wr   (ctrl_wr),
        .ctrl_rd   (ctrl_rd),
        .ctrl_addr (ctrl_addr),
        .ctrl_wdat (ctrl_wdat),
        .ctrl_rdat (ctrl_rdat),
        .ctrl_done (ctrl_done),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus transaction; drives on the falling edge, samples 1 time unit after rising.
    task automatic bus(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic ok);
        @(negedge clk);
        ctrl_wr   = wr;
        ctrl_rd   = ~wr;
        ctrl_addr = a;
        ctrl_wdat = d;
        ok = 1'b0;
        r  = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ctrl_done) begin
                ok = 1'b1;
                r  = ctrl_rdat;
                break;
            end
        end
        ctrl_wr = 1'b0;
        ctrl_rd = 1'b0;
        $display("bus %s addr=0x%02h wdat=0x%08h rdat=0x%08h done=%0d",
                 wr ? "wr" : "rd", a, d, r, ok);
    endtask

    task automatic wr_do(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic ok;
        bus(1'b1, a, d, r, ok);
        chk("wr_done", 32'(ok), 32'd1);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic ok;
        bus(1'b0, a, 32'd0, r, ok);
        chk(name, r, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        ok;
        logic        seen;

        vecs[0]  = '{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,         32'h0000_00FF};
        vecs[2]  = '{1'b1, 8'h08, 32'h1234_56A5, 32'h0};
        vecs[3]  = '{1'b0, 8'h08, 32'h0,         32'h0000_00A5};
        vecs[4]  = '{1'b1, 8'h10, 32'hABCD_1234, 32'h0};
        vecs[5]  = '{1'b0, 8'h10, 32'h0,         32'h0000_1234};
        vecs[6]  = '{1'b1, 8'h00, 32'h0000_00FF, 32'h0};
        vecs[7]  = '{1'b0, 8'h00, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 8'h14, 32'h0000_0055, 32'h0};
        vecs[9]  = '{1'b0, 8'h14, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0};
        vecs[11] = '{1'b0, 8'h0C, 32'h0,         32'h0};
        vecs[12] = '{1'b1, 8'h04, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 8'h08, 32'h0,         32'h0};
        vecs[14] = '{1'b0, 8'h04, 32'h0,         32'h0};

        reset = 1'b1; pin_in = '0; ctrl_wr = 1'b0; ctrl_rd = 1'b0;
        ctrl_addr = '0; ctrl_wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(ctrl_done), 32'd0);
        chk("rst_rdat", ctrl_rdat, 32'd0);
        chk("rst_irq",  32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Held read: completes every other cycle, data only with done.
        @(negedge clk);
        ctrl_rd = 1'b1; ctrl_addr = 8'h10;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held_done_%0d", i), 32'(ctrl_done), 32'(i % 2));
            chk($sformatf("held_rdat_%0d", i), ctrl_rdat, (i % 2 == 1) ? 32'h3E7 : 32'h0);
        end
        ctrl_rd = 1'b0;
        rd_chk("rst_level",  8'h00, 32'h0);
        rd_chk("rst_status", 8'h0C, 32'h0);

        for (int i = 0; i < 15; i++) begin
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wdat, r, ok);
            if (vecs[i].wr)
                chk($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
            else
                chk($sformatf("vec%0d_rdat", i), r, vecs[i].exp);
        end

        // Glitch shorter than three ticks at DIV=3 must be rejected.
        wr_do(8'h10, 32'd3);
        wr_do(8'h04, 32'h2);
        @(negedge clk);
        pin_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        pin_in[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            seen = seen | irq;
        end
        chk("glitch_irq", 32'(seen), 32'd0);
        rd_chk("glitch_level",  8'h00, 32'h0);
        rd_chk("glitch_status", 8'h0C, 32'h0);

        // Minimum-latency rising edge at DIV=0.
        wr_do(8'h10, 32'd0);
        wr_do(8'h04, 32'h1);
        @(negedge clk);
        pin_in[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            ctrl_rd = (c == 4 || c == 6); ctrl_addr = 8'h00;
            @(posedge clk);
            #1;
            chk($sformatf("lat_irq_%0d", c), 32'(irq), 32'(c >= 7));
            if (c == 4 || c == 6) begin
                chk($sformatf("lat_done_%0d", c), 32'(ctrl_done), 32'd1);
                chk($sformatf("lat_level_%0d", c), ctrl_rdat, (c == 6) ? 32'h1 : 32'h0);
            end
            ctrl_rd = 1'b0;
            @(negedge clk);
        end
        rd_chk("lat_status", 8'h0C, 32'h1);

        // Second enabled pin, then enable clear keeps status, then W1C.
        wr_do(8'h04, 32'h3);
        @(negedge clk);
        pin_in[1] = 1'b1;
        repeat (10) @(posedge clk);
        rd_chk("st3_status", 8'h0C, 32'h3);
        wr_do(8'h04, 32'h0);
        rd_chk("en_clr_status", 8'h0C, 32'h3);
        wr_do(8'h0C, 32'h1);
        rd_chk("w1c1_status", 8'h0C, 32'h2);
        chk("w1c1_irq", 32'(irq), 32'd1);
        wr_do(8'h0C, 32'h2);
        chk("w1c2_irq_same", 32'(irq), 32'd1);
        @(posedge clk);
        #1;
        chk("w1c2_irq_next", 32'(irq), 32'd0);
        rd_chk("w1c2_status", 8'h0C, 32'h0);

        // Falling event on bit 2 coinciding with a W1C of the same bit.
        wr_do(8'h08, 32'h4);
        @(negedge clk);
        pin_in[2] = 1'b1;
        repeat (10) @(posedge clk);
        rd_chk("fall_pre_status", 8'h0C, 32'h0);
        @(negedge clk);
        pin_in[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ctrl_wr = 1'b1; ctrl_addr = 8'h0C; ctrl_wdat = 32'h4;
        @(posedge clk);
        #1;
        chk("race_done", 32'(ctrl_done), 32'd1);
        ctrl_wr = 1'b0;
        rd_chk("race_status", 8'h0C, 32'h4);
        chk("race_irq", 32'(irq), 32'd1);
        wr_do(8'h0C, 32'h4);
        rd_chk("race_clr_status", 8'h0C, 32'h0);

        // Reset landing on a pending write aborts it; requests during reset ignored.
        pin_in[2:0] = 3'b111;
        @(posedge clk);
        #1;
        ctrl_wr = 1'b1; ctrl_addr = 8'h04; ctrl_wdat = 32'hFF;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            seen = seen | ctrl_done | (ctrl_rdat != 32'd0);
        end
        chk("abort_done", 32'(seen), 32'd0);
        @(negedge clk);
        reset = 1'b0; ctrl_wr = 1'b0;
        rd_chk("abort_rise_en", 8'h04, 32'h0);

        // Pins high through reset: rising events appear once LEVEL settles.
        wr_do(8'h04, 32'h6);
        rd_chk("pwr_div", 8'h10, 32'h3E7);
        chk("pwr_irq_early", 32'(irq), 32'd0);
        for (int i = 0; i < 6000 && !irq; i++) @(posedge clk);
        #1;
        chk("pwr_irq", 32'(irq), 32'd1);
        rd_chk("pwr_status", 8'h0C, 32'h6);
        rd_chk("pwr_level",  8'h00, 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icosoc_mod_pinevent.md
ICOSOC_MOD_PINEVENT -- requirements
Module: icosoc_mod_pinevent

Interface
REQ-001 SHALL have parameter IO_LENGTH, default 32: number of monitored pin inputs, 1..32.
REQ-002 SHALL have parameter DEFAULT_DIV, default 16'd999: reset value of prescaler reload register.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pin_in  input  IO_LENGTH  raw pad input levels from the GPIO block's D_IN_0 path, asynchronous to clk.
REQ-006 SHALL have port ctrl_wr  input  1  bus write request, held until ctrl_done.
REQ-007 SHALL have port ctrl_rd  input  1  bus read request, held until ctrl_done.
REQ-008 SHALL have port ctrl_addr  input  8  byte register address.
REQ-009 SHALL have port ctrl_wdat  input  32  write data.
REQ-010 SHALL have port ctrl_rdat  output  32  read data, valid in the ctrl_done cycle.
REQ-011 SHALL have port ctrl_done  output  1  one-cycle completion strobe.
REQ-012 SHALL have port irq  output  1  registered, level interrupt request.

Function
REQ-013 Registers: 0x00 LEVEL (RO, filtered levels); 0x04 RISE_EN (RW); 0x08 FALL_EN (RW); 0x0C STATUS (read; write-1-to-clear); 0x10 DIV (RW, bits 15:0).
REQ-014 Bits at or above IO_LENGTH SHALL read 0 and ignore writes; DIV bits 31:16 SHALL read 0.
REQ-015 Handshake: request seen with ctrl_done=0 -> ctrl_done=1 next cycle; ctrl_done SHALL never be high two consecutive cycles; a request held across ctrl_done SHALL be serviced once per done pulse.
REQ-016 ctrl_rdat SHALL be 0 in every cycle where ctrl_done=0, and 0 on reads of unmapped addresses; writes to unmapped or RO addresses SHALL complete with no effect.
REQ-017 pin_in SHALL pass through a 2-flop synchronizer per bit before any use.
REQ-018 Prescaler: 16-bit down-counter; at 0 emits a one-cycle tick and reloads from DIV; tick period = DIV+1 cycles; DIV=0 gives a tick every cycle.
REQ-019 A DIV write SHALL reload the counter with the new value in the same cycle it updates DIV.
REQ-020 Per bit, on each tick, sample the synchronized input into a 3-deep history; LEVEL bit SHALL change only when all 3 samples equal each other and differ from current LEVEL, updating in the cycle after the tick.
REQ-021 A LEVEL 0->1 transition with RISE_EN bit set, or 1->0 with FALL_EN bit set, SHALL set the STATUS bit in the following cycle.
REQ-022 Event set and W1C clear hitting the same STATUS bit in the same cycle: set SHALL win.
REQ-023 Clearing an enable bit SHALL NOT clear already-set STATUS bits.
REQ-024 irq SHALL equal the OR of STATUS, registered one cycle later.
REQ-025 Minimum latency, DIV=0, clean pin edge: LEVEL changes 5 cycles after pin_in changes (2 sync + 3 samples), STATUS 1 cycle later, irq 1 cycle after that.

Reset
REQ-026 With reset high at a clk edge: LEVEL, sample histories, synchronizers, RISE_EN, FALL_EN, STATUS = 0; DIV = DEFAULT_DIV; counter = DEFAULT_DIV; ctrl_done=0; ctrl_rdat=0; irq=0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no register update and no ctrl_done; requests present while reset is high SHALL be ignored.
REQ-028 Pins held high through reset SHALL produce a rising event after reset only if RISE_EN is set before LEVEL settles.

Structure
REQ-029 Register offsets and their widths SHALL be constants in shared package icosoc_pinevent_pkg.
REQ-030 Per-pin synchronizer, history and LEVEL logic SHALL be sub-module icosoc_pinevent_filter, instantiated IO_LENGTH times; prescaler, register file and irq stay in the top.

Verification
REQ-031 DIV=0, RISE_EN=0x1, pin_in[0] 0->1 -> LEVEL[0]=1 at +5 cycles, STATUS=0x1 at +6, irq=1 at +7.
REQ-032 DIV=3, pin_in[1] glitches high for 6 cycles -> LEVEL[1] stays 0, STATUS stays 0, irq stays 0.
REQ-033 STATUS=0x3, write 0x1 to 0x0C -> read 0x0C returns 0x2, irq stays 1; write 0x2 -> STATUS=0, irq=0 one cycle later.
REQ-034 FALL_EN bit 2 event and W1C of 0x4 in the same cycle -> STATUS bit 2 remains 1.
REQ-035 ctrl_rd held continuously on 0x10 after reset -> ctrl_done pulses every other cycle, rdat=DEFAULT_DIV (0x3E7) each pulse; read 0x14 -> 0.
REQ-036 Reset raised the cycle after a write to 0x04 is issued -> no ctrl_done, RISE_EN reads 0 after reset.
